// File: rtl/e32_fetch.sv
// e32 instruction fetch stage: issues sequential word reads and buffers
// returned instructions with their addresses in a small FIFO for decode.
module e32_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  input  logic [31:0] mem_data_i,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_t;

  state_t state, state_nx;

  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic          inflight;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic [31:0]   q_data [DEPTH];
  logic [31:0]   q_pc   [DEPTH];

  logic flush;
  logic push;
  logic pop;
  logic unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  always_comb begin
    state_nx = state;
    unique case (state)
      BOOT:    state_nx = enable ? RUN : HALT;
      RUN:     if (!enable) state_nx = HALT;
      HALT:    if (enable) state_nx = RUN;
      default: state_nx = BOOT;
    endcase
  end

  // Queue slots reserved by an outstanding read count as occupied.
  assign occ   = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign flush = redirect && (state != BOOT);
  assign push  = inflight && !flush;
  assign pop   = instr_valid && instr_ready && !flush;

  assign mem_read = (state == RUN) && enable && !redirect
                  && (occ < (CW+1)'(DEPTH));
  assign mem_addr    = fetch_pc;
  assign instr_valid = (count != '0);
  assign instr       = q_data[rd_ptr];
  assign instr_pc    = q_pc[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= state_nx;
      inflight <= mem_read;
      if (mem_read) req_pc <= fetch_pc;
      if (flush) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (mem_read) fetch_pc <= fetch_pc + 32'd4;
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        unique case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= mem_data_i;
      q_pc[wr_ptr]   <= req_pc;
    end
  end

endmodule

// File: doc/e32_fetch.md
E32_FETCH -- requirements
Module: e32_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4: instruction queue entries; a power of two, at least 2.
REQ-003 SHALL have port clk  input  1  single clock; all state on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  core run enable; low blocks new fetch requests.
REQ-006 SHALL have port redirect  input  1  branch/jump taken; flush and restart fetch.
REQ-007 SHALL have port redirect_pc  input  32  new fetch address, sampled while redirect=1.
REQ-008 SHALL have port mem_addr  output  32  instruction word address.
REQ-009 SHALL have port mem_read  output  1  fetch request strobe, one cycle per word.
REQ-010 SHALL have port mem_data_i  input  32  read data, valid exactly 1 cycle after mem_read=1.
REQ-011 SHALL have port instr_valid  output  1  queue head holds an instruction.
REQ-012 SHALL have port instr_ready  input  1  decode accepts the head this cycle.
REQ-013 SHALL have port instr  output  32  head instruction word.
REQ-014 SHALL have port instr_pc  output  32  address of the head instruction.

Function
REQ-015 SHALL use FSM states BOOT, RUN and HALT; BOOT is the reset state.
REQ-016 BOOT SHALL last one cycle with no request, then go to RUN if enable=1, else HALT.
REQ-017 RUN SHALL go to HALT when enable=0; HALT SHALL go to RUN when enable=1.
REQ-018 SHALL assert mem_read only in RUN, with redirect=0 and (count + inflight) < DEPTH.
REQ-019 SHALL drive mem_addr = fetch_pc on every cycle.
REQ-020 SHALL advance fetch_pc by 4 on each issued request, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
REQ-021 SHALL set inflight=1 the cycle after a request and capture mem_data_i with its address that cycle.
REQ-022 SHALL push each captured word into the queue unless a redirect occurred since issue.
REQ-023 A word fetched before a redirect SHALL be dropped and its inflight slot freed.
REQ-024 On redirect=1 (any state except BOOT): queue emptied, fetch_pc <= {redirect_pc[31:2], 2'b00}, no request that cycle.
REQ-025 The first request after a redirect SHALL issue the next cycle if REQ-018 holds.
REQ-026 redirect SHALL take priority over push and pop in the same cycle.
REQ-027 A pop on that cycle is ignored by fetch and treated as not accepted.
REQ-028 SHALL set instr_valid = (count != 0).
REQ-029 instr and instr_pc SHALL be the stored head entry, driven straight from queue storage.
REQ-030 A pop SHALL occur when instr_valid && instr_ready; pop and push in one cycle SHALL leave count unchanged.
REQ-031 count SHALL never exceed DEPTH and SHALL never underflow; pop on empty is a no-op.
REQ-032 HALT SHALL still capture an in-flight response and serve pops.
REQ-033 enable SHALL NOT affect the output handshake.

Reset
REQ-034 reset=0 SHALL immediately set the FSM to BOOT and fetch_pc to RESET_PC.
REQ-035 reset=0 SHALL immediately clear count, pointers and inflight, and drive mem_read=0 and instr_valid=0.
REQ-036 A reset during an in-flight fetch SHALL discard that response.
REQ-037 instr and instr_pc are don't-care while instr_valid=0.
REQ-038 Release of reset SHALL be synchronous to clk; the first request is in the second cycle after release.

Verification
REQ-039 Straight-line fetch: release reset, enable=1, instr_ready=1, memory returns addr^32'hA5A5_0000 -> instr_pc 0,4,8,... in order, matching data.
REQ-040 Backpressure: instr_ready=0 -> exactly 4 requests issue, then mem_read stays 0 while count=4; one pop -> exactly one new request.
REQ-041 Redirect with in-flight word: redirect=1, redirect_pc=32'h0000_0103 while inflight=1 -> old word dropped, queue empty, next mem_addr=32'h0000_0100.
REQ-042 Wrap: RESET_PC=32'hFFFF_FFF8 -> instr_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-043 Enable toggle: enable=0 for 5 cycles mid-stream -> no requests, pending word still delivered, fetch resumes at the next sequential address.
REQ-044 Async reset mid-stream: reset=0 between clock edges -> instr_valid and mem_read drop at once; after release, fetch restarts at RESET_PC.
